// File: rtl/l1_iface_pkg.sv
// Shared types and helpers for the L1_D miss-forwarding interface.
package l1_iface_pkg;

    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned WDATA_W    = 64;
    localparam int unsigned OFFSET_W   = 4;

    typedef enum logic [2:0] {
        SZ_1B = 3'd0,
        SZ_2B = 3'd1,
        SZ_4B = 3'd2,
        SZ_8B = 3'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Request fields captured on accept; the line index is held separately.
    typedef struct packed {
        logic                write;
        logic                clf;
        logic [2:0]          size;
        logic [OFFSET_W-1:0] offset;
        logic [WDATA_W-1:0]  wdata;
    } req_t;

    // Access size in bytes; 0 marks an illegal encoding.
    function automatic logic [3:0] size_to_bytes(input logic [2:0] size);
        logic [3:0] nbytes;
        case (size)
            SZ_1B:   nbytes = 4'd1;
            SZ_2B:   nbytes = 4'd2;
            SZ_4B:   nbytes = 4'd4;
            SZ_8B:   nbytes = 4'd8;
            default: nbytes = 4'd0;
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/line_merge.sv
// Little-endian merge of the low bytes of a 64-bit write word into a 16-byte line.
module line_merge
    import l1_iface_pkg::*;
(
    input  logic [8*LINE_BYTES-1:0] line,
    input  logic [WDATA_W-1:0]      wdata,
    input  logic [OFFSET_W-1:0]     offset,
    input  logic [2:0]              size,
    output logic [8*LINE_BYTES-1:0] merged,
    output logic                    misaligned
);

    logic [3:0] nbytes;

    assign nbytes = size_to_bytes(size);

    // Byte k of wdata lands at line byte offset+k; bytes past the line end are dropped.
    always_comb begin
        merged = line;
        for (int k = 0; k < 8; k++) begin
            if ((4'(k) < nbytes) && ((5'(offset) + 5'(k)) < 5'(LINE_BYTES))) begin
                merged[(int'(offset) + k)*8 +: 8] = wdata[k*8 +: 8];
            end
        end
    end

    assign misaligned = (nbytes != 4'd0) && ((offset & (nbytes - 4'd1)) != 4'd0);

endmodule

// File: rtl/l1_fill_responder.sv
// Lower-level responder for L1_D misses: services reads, writes and line flushes
// from a line-organised store after a fixed latency.
module l1_fill_responder
    import l1_iface_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [2:0]        req_size,
    input  logic              req_clf,
    output logic              enable_out,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_valid,
    output logic              resp_err
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 4;

    state_e            state;
    state_e            next_state;
    logic [CNT_W-1:0]  cnt;
    req_t              req_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LINE_W-1:0] store [DEPTH];

    logic [LINE_W-1:0] cur_line_c;
    logic [LINE_W-1:0] merged_c;
    logic              misaligned_c;
    logic              fire_c;
    logic              err_c;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[ADDR_W-1:OFFSET_W+IDX_W];

    assign cur_line_c = store[idx_q];
    assign fire_c     = (state == ST_BUSY) && (cnt == '0);
    assign err_c      = (req_q.size > 3'(SZ_8B)) || misaligned_c;

    line_merge u_merge (
        .line       (cur_line_c),
        .wdata      (req_q.wdata),
        .offset     (req_q.offset),
        .size       (req_q.size),
        .merged     (merged_c),
        .misaligned (misaligned_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_valid) next_state = ST_BUSY;
            ST_BUSY: if (cnt == '0) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Request capture, latency counter and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            req_q      <= '0;
            idx_q      <= '0;
            enable_out <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
        end else begin
            enable_out <= (next_state != ST_BUSY);
            resp_valid <= (next_state == ST_DONE);

            if ((state == ST_IDLE) && req_valid) begin
                req_q.write  <= req_write;
                req_q.clf    <= req_clf;
                req_q.size   <= req_size;
                req_q.offset <= req_addr[OFFSET_W-1:0];
                req_q.wdata  <= req_wdata;
                idx_q        <= req_addr[OFFSET_W+IDX_W-1:OFFSET_W];
                cnt          <= CNT_W'(LATENCY - 1);
            end else if ((state == ST_BUSY) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (fire_c) begin
                resp_err <= err_c;
                if (err_c) begin
                    resp_data <= '0;
                end else if (req_q.clf || !req_q.write) begin
                    resp_data <= cur_line_c;
                end else begin
                    resp_data <= merged_c;
                end
            end else if (next_state == ST_IDLE) begin
                resp_err <= 1'b0;
            end
        end
    end

    // Backing store; flush takes priority over write, errors leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                store[i] <= '0;
            end
        end else if (fire_c && !err_c) begin
            if (req_q.clf) begin
                store[idx_q] <= '0;
            end else if (req_q.write) begin
                store[idx_q] <= merged_c;
            end
        end
    end

endmodule

// File: tb/tb_l1_fill_responder.sv
// Directed scoreboard bench for l1_fill_responder with a byte-level store model.
module tb_l1_fill_responder;

    localparam int unsigned LAT = 4;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_write;
    logic [63:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [2:0]   req_size;
    logic         req_clf;
    logic         enable_out;
    logic [127:0] resp_data;
    logic         resp_valid;
    logic         resp_err;

    int tests = 0;
    int fails = 0;

    logic [7:0] mb [64][16];
    exp_t       sb [$];

    always #5 clk = ~clk;

    l1_fill_responder #(
        .ADDR_W (64), .LINE_W (128), .IDX_W (6), .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_clf    (req_clf),
        .enable_out (enable_out),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_line(input int idx);
        logic [127:0] l;
        for (int b = 0; b < 16; b++) l[b*8 +: 8] = mb[idx][b];
        return l;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++)
            for (int b = 0; b < 16; b++) mb[i][b] = 8'h00;
    endtask

    // Apply one request to the model and return what the responder should report.
    function automatic exp_t model_req(input logic w, input logic [63:0] a,
                                       input logic [63:0] d, input logic [2:0] s,
                                       input logic c);
        exp_t e;
        int idx, off, nb;
        idx = int'(a[9:4]);
        off = int'(a[3:0]);
        nb  = (s <= 3'd3) ? (1 << s) : 0;
        e.err  = (nb == 0) || ((off % nb) != 0);
        e.data = '0;
        if (!e.err) begin
            if (c) begin
                e.data = model_line(idx);
                for (int b = 0; b < 16; b++) mb[idx][b] = 8'h00;
            end else begin
                if (w)
                    for (int k = 0; k < nb; k++) mb[idx][off + k] = d[k*8 +: 8];
                e.data = model_line(idx);
            end
        end
        return e;
    endfunction

    task automatic send(input string tag, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [2:0] s, input logic c);
        exp_t e;
        int   low;
        bit   got;
        @(negedge clk);
        chk({tag, "_idle_en"}, 128'(enable_out), 128'(1));
        chk({tag, "_idle_err"}, 128'(resp_err), 128'(0));
        req_valid = 1'b1; req_write = w; req_addr = a;
        req_wdata = d; req_size = s; req_clf = c;
        sb.push_back(model_req(w, a, d, s, c));
        @(posedge clk);
        #1 req_valid = 1'b0;
        low = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
            else if (!enable_out) low++;
        end
        chk({tag, "_resp_seen"}, 128'(got), 128'(1));
        if (got) begin
            e = sb.pop_front();
            chk({tag, "_busy_cycles"}, 128'(low), 128'(LAT));
            chk({tag, "_done_en"}, 128'(enable_out), 128'(1));
            chk({tag, "_data"}, resp_data, e.data);
            chk({tag, "_err"}, 128'(resp_err), 128'(e.err));
        end else if (sb.size() != 0) begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int pulses, first, last;
        logic [127:0] snap;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = 3'd3; req_clf = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_en", 128'(enable_out), 128'(1));
        chk("rst_valid", 128'(resp_valid), 128'(0));
        chk("rst_err", 128'(resp_err), 128'(0));
        chk("rst_data", resp_data, 128'(0));
        reset = 1'b0;

        send("rd_zero", 1'b0, 64'h40, 64'h0, 3'd3, 1'b0);
        send("wr_8b", 1'b1, 64'h48, 64'h1122334455667788, 3'd3, 1'b0);
        send("rd_after_wr", 1'b0, 64'h40, 64'h0, 3'd3, 1'b0);
        chk("rd_after_wr_const", resp_data, 128'h1122334455667788_0000000000000000);

        send("wr_1b", 1'b1, 64'h4F, 64'hFFFF_FFFF_FFFF_FFAB, 3'd0, 1'b0);
        send("clf", 1'b0, 64'h40, 64'h0, 3'd3, 1'b1);
        chk("clf_byte15", 128'(resp_data[127:120]), 128'(8'hAB));
        send("rd_after_clf", 1'b0, 64'h40, 64'h0, 3'd3, 1'b0);

        send("wr_alias", 1'b1, 64'hFFFF_0000_0000_0040, 64'hCAFE_F00D_DEAD_BEEF, 3'd3, 1'b0);
        send("wr_2b", 1'b1, 64'hC6, 64'h0000_0000_0000_5A5A, 3'd1, 1'b0);
        send("rd_2b", 1'b0, 64'hC0, 64'h0, 3'd3, 1'b0);
        snap = model_line(4);
        send("wr_misalign", 1'b1, 64'h42, 64'h0000_0000_1234_5678, 3'd2, 1'b0);
        send("bad_size", 1'b1, 64'h40, 64'h0000_0000_0000_0099, 3'd5, 1'b0);
        send("rd_unchanged", 1'b0, 64'h40, 64'h0, 3'd3, 1'b0);
        chk("rd_unchanged_snap", resp_data, snap);

        // Continuous req_valid: one response per IDLE accept, LAT+2 apart.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h40; req_size = 3'd3; req_clf = 1'b0;
        pulses = 0; first = 0; last = 0;
        for (int n = 1; n <= 3*(LAT+2); n++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                if (first == 0) first = n;
                last = n;
                chk("hold_data", resp_data, model_line(4));
            end
        end
        req_valid = 1'b0;
        chk("hold_pulses", 128'(pulses), 128'(3));
        chk("hold_first", 128'(first), 128'(LAT+1));
        chk("hold_last", 128'(last), 128'(3*(LAT+2)-1));

        // Reset in BUSY aborts a write to 0x80.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h80;
        req_wdata = 64'h0102030405060708; req_size = 3'd3; req_clf = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_en", 128'(enable_out), 128'(0));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        @(negedge clk);
        chk("abort_en", 128'(enable_out), 128'(1));
        pulses = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            if (resp_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_no_resp", 128'(pulses), 128'(0));
        send("rd_after_abort", 1'b0, 64'h80, 64'h0, 3'd3, 1'b0);
        send("rd_line4_cleared", 1'b0, 64'h40, 64'h0, 3'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
